// File: rtl/fpu_pkg.sv
// Shared FP32 constants for the FPU slice: flag bit positions, canonical qNaN
// and the adder pipeline depth.
package fpu_pkg;

    localparam int FLG_INV = 4;
    localparam int FLG_DZ  = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    localparam logic [31:0] FP32_QNAN = 32'h7FC00000;

    localparam int FPU_ADD_LAT = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: picks the first eligible index at or after rr_ptr,
// then moves rr_ptr just past the winner.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] eligible,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx,
    output logic             grant_any
);

    logic [IDW-1:0] rr_ptr;

    always_comb begin
        int idx;
        logic [IDW-1:0] pos;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        pos       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            pos = IDW'(idx);
            if (!grant_any && eligible[pos]) begin
                grant[pos] = 1'b1;
                grant_idx  = pos;
                grant_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one pipelined FP32 adder among N_REQ requesters; a tag pipeline matched
// to the adder latency steers each result back to its requester's response slot.
module fpu_add_arbiter
    import fpu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int LAT   = FPU_ADD_LAT,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*32-1:0]  req_a,
    input  logic [N_REQ*32-1:0]  req_b,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [N_REQ*32-1:0]  rsp_result,
    output logic [N_REQ*5-1:0]   rsp_flags,
    output logic                 fpu_start,
    output logic [31:0]          fpu_a,
    output logic [31:0]          fpu_b,
    input  logic                 fpu_valid,
    input  logic [31:0]          fpu_result,
    input  logic [4:0]           fpu_flags,
    output logic                 tag_err
);

    // Handshakes: a request transfers in a cycle where req_valid[i] & req_ready[i];
    // req_ready is combinational and may depend on req_valid. A response transfers
    // where rsp_valid[i] & rsp_ready[i]; rsp_valid never depends on rsp_ready.

    logic [N_REQ-1:0] busy;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;

    logic             tag_v  [LAT];
    logic [IDW-1:0]   tag_id [LAT];

    logic             last_v;
    logic [IDW-1:0]   last_id;
    logic             slot_write;
    logic             tag_lost;

    assign eligible = rst ? '0 : (req_valid & ~busy);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .eligible  (eligible),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant;
    assign fpu_start = grant_any;
    assign fpu_a     = grant_any ? req_a[32*int'(grant_idx) +: 32] : '0;
    assign fpu_b     = grant_any ? req_b[32*int'(grant_idx) +: 32] : '0;

    assign last_v     = tag_v[LAT-1];
    assign last_id    = tag_id[LAT-1];
    assign slot_write = fpu_valid & last_v;
    // A tag with no result must still free its requester, or it would never be re-granted.
    assign tag_lost   = last_v & ~fpu_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            tag_err    <= 1'b0;
            for (int s = 0; s < LAT; s++) begin
                tag_v[s]  <= 1'b0;
                tag_id[s] <= '0;
            end
        end else begin
            tag_v[0]  <= grant_any;
            tag_id[0] <= grant_idx;
            for (int s = 1; s < LAT; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end

            if (fpu_valid != last_v) begin
                tag_err <= 1'b1;
            end

            for (int i = 0; i < N_REQ; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    busy[i]      <= 1'b0;
                    rsp_valid[i] <= 1'b0;
                end
                if (tag_lost && last_id == IDW'(i)) begin
                    busy[i] <= 1'b0;
                end
                if (grant[i]) begin
                    busy[i] <= 1'b1;
                end
                if (slot_write && last_id == IDW'(i)) begin
                    rsp_valid[i]           <= 1'b1;
                    rsp_result[32*i +: 32] <= fpu_result;
                    rsp_flags[5*i +: 5]    <= fpu_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Bench for fpu_add_arbiter: behavioural adder stub plus a cycle-level reference
// model of the arbitration and response rules, with directed and random phases.
module tb_fpu_add_arbiter;
    import fpu_pkg::*;

    localparam int N   = 4;
    localparam int LAT = FPU_ADD_LAT;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '1;
    logic [N*32-1:0] rsp_result;
    logic [N*5-1:0]  rsp_flags;
    logic            fpu_start;
    logic [31:0]     fpu_a, fpu_b;
    logic            fpu_valid;
    logic [31:0]     fpu_result;
    logic [4:0]      fpu_flags;
    logic            tag_err;
    logic            inj  = 1'b0;
    logic            drop = 1'b0;

    int checks = 0;
    int errors = 0;

    fpu_add_arbiter #(.N_REQ(N), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .fpu_start  (fpu_start),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_valid  (fpu_valid),
        .fpu_result (fpu_result),
        .fpu_flags  (fpu_flags),
        .tag_err    (tag_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Adder behaviour: exact sums for the directed vectors, an opaque mix otherwise.
    function automatic logic [36:0] add_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return {5'b00000, 32'h40400000};
            {32'h3F800000, 32'h3F800000}: return {5'b00000, 32'h40000000};
            {32'h40000000, 32'h40000000}: return {5'b00000, 32'h40800000};
            {32'h40800000, 32'h40800000}: return {5'b00000, 32'h41000000};
            {32'h7F800000, 32'hFF800000}: return {5'b10000, 32'h7FC00000};
            {32'h7F7FFFFF, 32'h7F7FFFFF}: return {5'b00101, 32'h7F800000};
            default: return {a[4:0] ^ b[9:5], a + b};
        endcase
    endfunction

    // ---------------- adder stub ----------------
    logic        st_v [LAT];
    logic [36:0] st_d [LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                st_v[s] <= 1'b0;
                st_d[s] <= '0;
            end
        end else begin
            st_v[0] <= fpu_start;
            st_d[0] <= add_model(fpu_a, fpu_b);
            for (int s = 1; s < LAT; s++) begin
                st_v[s] <= st_v[s-1];
                st_d[s] <= st_d[s-1];
            end
        end
    end

    assign fpu_valid  = (st_v[LAT-1] | inj) & ~drop;
    assign fpu_result = st_d[LAT-1][31:0];
    assign fpu_flags  = st_d[LAT-1][36:32];

    // ---------------- driver tasks ----------------
    logic [63:0] op_q [N][$];

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < N; i++) begin
            if (op_q[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_a[32*i +: 32]  = op_q[i][0][63:32];
                req_b[32*i +: 32]  = op_q[i][0][31:0];
            end else begin
                req_valid[i]       = 1'b0;
                req_a[32*i +: 32]  = $urandom;
                req_b[32*i +: 32]  = $urandom;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [N-1:0] m_busy = '0;
    logic [N-1:0] m_rv   = '0;
    int           m_cnt [N];
    int           m_ptr  = 0;
    logic         m_err  = 1'b0;
    logic [36:0]  m_slot [N];
    logic [36:0]  exp_q  [N][$];
    logic         rst_prev = 1'b0;

    always @(negedge clk) begin
        logic [N-1:0] elig, egr;
        logic [31:0]  ea, eb;
        int           g, lid;
        logic         lv, fv;
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_fpu_start", fpu_start, 0);
            chk("rst_fpu_ab", {fpu_a, fpu_b}, 0);
            if (rst_prev) begin
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_tag_err", tag_err, 0);
                chk("rst_rsp_result", rsp_result[63:0] | rsp_result[127:64], 0);
                chk("rst_rsp_flags", rsp_flags, 0);
            end
            m_busy = '0;
            m_rv   = '0;
            m_ptr  = 0;
            m_err  = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_cnt[i]  = 0;
                m_slot[i] = '0;
                exp_q[i].delete();
            end
        end else begin
            elig = req_valid & ~m_busy;
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && elig[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            egr = '0;
            ea  = '0;
            eb  = '0;
            if (g >= 0) begin
                egr[g] = 1'b1;
                ea = req_a[32*g +: 32];
                eb = req_b[32*g +: 32];
            end
            chk("req_ready", req_ready, egr);
            chk("fpu_start", fpu_start, g >= 0);
            chk("fpu_a", fpu_a, ea);
            chk("fpu_b", fpu_b, eb);
            chk("rsp_valid", rsp_valid, m_rv);
            chk("tag_err", tag_err, m_err);
            for (int i = 0; i < N; i++) begin
                chk($sformatf("rsp_result%0d", i), rsp_result[32*i +: 32], m_slot[i][31:0]);
                chk($sformatf("rsp_flags%0d", i), rsp_flags[5*i +: 5], m_slot[i][36:32]);
            end

            // A result is due for requester i when its countdown is at its last cycle.
            lv = 1'b0;
            lid = 0;
            for (int i = 0; i < N; i++) begin
                if (m_busy[i] && !m_rv[i] && m_cnt[i] == 1) begin
                    lv = 1'b1;
                    lid = i;
                end
            end
            fv = (lv | inj) & ~drop;
            if (fv != lv) m_err = 1'b1;
            if (lv && !fv) begin
                m_busy[lid] = 1'b0;
                m_cnt[lid]  = 0;
                void'(exp_q[lid].pop_front());
            end
            for (int i = 0; i < N; i++) begin
                if (m_rv[i] && rsp_ready[i]) begin
                    m_rv[i]   = 1'b0;
                    m_busy[i] = 1'b0;
                end
                if (m_cnt[i] > 0) begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) begin
                        m_rv[i]   = 1'b1;
                        m_slot[i] = exp_q[i].pop_front();
                    end
                end
            end
            if (g >= 0) begin
                m_busy[g] = 1'b1;
                m_cnt[g]  = LAT;
                exp_q[g].push_back(add_model(ea, eb));
                m_ptr = (g + 1) % N;
                void'(op_q[g].pop_front());
            end
        end
        rst_prev = rst;
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int n2, nother;
        logic [4:0] fexp;

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Single operation on requester 1.
        op_q[1].push_back({32'h3F800000, 32'h40000000});
        repeat (5) @(negedge clk);
        chk("single_rsp_valid", rsp_valid[1], 1);
        chk("single_result", rsp_result[63:32], 32'h40400000);
        chk("single_flags", rsp_flags[9:5], 5'b00000);
        repeat (4) step();

        // Contention from a fresh reset.
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        op_q[0].push_back({32'h3F800000, 32'h3F800000});
        op_q[1].push_back({32'h3F800000, 32'h40000000});
        op_q[2].push_back({32'h40000000, 32'h40000000});
        op_q[3].push_back({32'h40800000, 32'h40800000});
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk($sformatf("cont_grant%0d", k), req_ready, 4'b0001 << k);
            chk("cont_start", fpu_start, 1);
        end
        @(negedge clk);
        chk("cont_start_end", fpu_start, 0);
        repeat (8) step();

        // Backpressure on requester 2.
        rsp_ready[2] = 1'b0;
        op_q[0].push_back({32'h3F800000, 32'h3F800000});
        op_q[0].push_back({32'h40000000, 32'h40000000});
        op_q[1].push_back({32'h3F800000, 32'h40000000});
        op_q[1].push_back({32'h40800000, 32'h40800000});
        op_q[3].push_back({32'h3F800000, 32'h3F800000});
        op_q[3].push_back({32'h40000000, 32'h40000000});
        repeat (3) op_q[2].push_back({$urandom, $urandom});
        n2 = 0;
        nother = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n2     += int'(req_ready[2]);
            nother += int'(req_ready[0]) + int'(req_ready[1]) + int'(req_ready[3]);
        end
        chk("bp_grants_held", n2, 1);
        chk("bp_grants_others", nother, 6);
        step();
        rsp_ready[2] = 1'b1;
        @(negedge clk);
        chk("bp_rsp_pending", rsp_valid[2], 1);
        @(negedge clk);
        chk("bp_regrant", req_ready[2], 1);
        repeat (20) step();

        // Special operands routed back to their own slots.
        rsp_ready[0] = 1'b0;
        rsp_ready[3] = 1'b0;
        op_q[0].push_back({32'h7F800000, 32'hFF800000});
        op_q[3].push_back({32'h7F7FFFFF, 32'h7F7FFFFF});
        repeat (7) step();
        @(negedge clk);
        chk("spec_valid", {rsp_valid[0], rsp_valid[3]}, 2'b11);
        chk("spec_res0", rsp_result[31:0], FP32_QNAN);
        fexp = '0;
        fexp[FLG_INV] = 1'b1;
        chk("spec_flg0", rsp_flags[4:0], fexp);
        chk("spec_res3", rsp_result[127:96], 32'h7F800000);
        fexp = '0;
        fexp[FLG_OVF] = 1'b1;
        fexp[FLG_INX] = 1'b1;
        chk("spec_flg3", rsp_flags[19:15], fexp);
        step();
        rsp_ready = '1;
        repeat (3) step();

        // Reset in the middle of two operations.
        op_q[0].push_back({32'h3F800000, 32'h3F800000});
        op_q[1].push_back({32'h40000000, 32'h40000000});
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rst_flight_none", rsp_valid, 0);
        end
        step();
        op_q[2].push_back({32'h3F800000, 32'h40000000});
        repeat (5) @(negedge clk);
        chk("post_rst_valid", rsp_valid[2], 1);
        chk("post_rst_result", rsp_result[95:64], 32'h40400000);
        repeat (4) step();

        // Spurious adder valid with nothing in flight.
        inj = 1'b1;
        step();
        inj = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("tag_err_held", tag_err, 1);
            chk("tag_no_slot", rsp_valid, 0);
        end
        step();

        // Adder drops a result: requester must still be freed.
        drop = 1'b1;
        op_q[1].push_back({32'h40000000, 32'h40000000});
        repeat (6) step();
        drop = 1'b0;
        op_q[1].push_back({32'h3F800000, 32'h3F800000});
        @(negedge clk);
        chk("drop_regrant", req_ready[1], 1);
        repeat (8) step();

        // Random traffic and response backpressure.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (op_q[i].size() < 2 && $urandom_range(0, 3) == 0)
                    op_q[i].push_back({$urandom, $urandom});
            end
            rsp_ready = N'($urandom_range(0, (1 << N) - 1));
            step();
        end
        rsp_ready = '1;
        repeat (40) step();

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
